aes_round_sequencer: RTL and testbench

- Top-level controller for the iterative AES-128 round core (enable / i_text / key / round in; o_text / Rkey / done out).
- Accepts one plaintext/key pair over a valid/ready handshake and applies the initial AddRoundKey whitening.
- Issues the 10 round operations to the core one at a time, carrying state and round key between rounds.
- Returns the ciphertext over a valid/ready handshake. Includes a per-round watchdog that flags a hung core.

---
 rtl/aes_round_sequencer.sv | 165 ++++++++++++++++
 tb/tb_aes_round_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// -----------------------------------------------------------------------------
// aes_round_sequencer
//
// Top-level controller for an iterative AES-128 round core. It takes one
// plaintext/key pair per block and applies the initial AddRoundKey whitening.
// It then issues the round operations to the core one at a time, carrying
// the state and the round key between rounds, and returns the ciphertext.
// A per-round watchdog parks the sequencer in a sticky fault state if the
// core never reports completion.
//
// Ports:
//   clock, resetn            system clock, asynchronous active-low reset
//   in_valid/in_ready        input handshake (in_text, in_key; byte 0 = [7:0])
//   out_valid/out_ready      output handshake (out_text)
//   busy                     high whenever the sequencer is not idle
//   error / err_clr          sticky watchdog fault and its clear
//   core_enable              one-cycle start pulse to the round core
//   core_text/core_key       state and round key presented to the core
//   core_round               round index 0..NUM_ROUNDS-1
//   core_o_text/core_rkey    core results, valid the cycle after core_done
//   core_done                core round-complete pulse
// -----------------------------------------------------------------------------
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int TIMEOUT    = 64
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_text,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_text,
    output logic         busy,
    output logic         error,
    input  logic         err_clr,
    output logic         core_enable,
    output logic [127:0] core_text,
    output logic [127:0] core_key,
    output logic [3:0]   core_round,
    input  logic [127:0] core_o_text,
    input  logic [127:0] core_rkey,
    input  logic         core_done
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_OUT     = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;

    localparam logic [3:0]      LAST_ROUND = 4'(NUM_ROUNDS - 1);
    localparam logic [WD_W-1:0] WD_LIMIT   = WD_W'(TIMEOUT - 1);

    logic [2:0]      state_q,    state_d;
    logic [127:0]    text_q,     text_d;
    logic [127:0]    key_q,      key_d;
    logic [3:0]      round_q,    round_d;
    logic [WD_W-1:0] wd_cnt_q,   wd_cnt_d;
    logic [127:0]    out_text_q, out_text_d;

    always_comb begin
        state_d    = state_q;
        text_d     = text_q;
        key_d      = key_q;
        round_d    = round_q;
        wd_cnt_d   = wd_cnt_q;
        out_text_d = out_text_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Initial AddRoundKey whitening happens here, so round 0
                    // of the core already sees the whitened state.
                    text_d  = in_text ^ in_key;
                    key_d   = in_key;
                    round_d = 4'd0;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                wd_cnt_d = '0;
                state_d  = S_WAIT;
            end

            S_WAIT: begin
                wd_cnt_d = wd_cnt_q + WD_W'(1);
                // A completion in the very last allowed cycle still wins
                // over the timeout.
                if (core_done) begin
                    state_d = S_CAPTURE;
                end else if (wd_cnt_q == WD_LIMIT) begin
                    state_d = S_FAULT;
                end
            end

            S_CAPTURE: begin
                text_d = core_o_text;
                if (round_q == LAST_ROUND) begin
                    // The core hands back a fixed key after its final round,
                    // so the key register is deliberately left alone.
                    out_text_d = core_o_text;
                    state_d    = S_OUT;
                end else begin
                    key_d   = core_rkey;
                    round_d = round_q + 4'd1;
                    state_d = S_ISSUE;
                end
            end

            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            S_FAULT: begin
                if (err_clr) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            text_q     <= '0;
            key_q      <= '0;
            round_q    <= '0;
            wd_cnt_q   <= '0;
            out_text_q <= '0;
        end else begin
            state_q    <= state_d;
            text_q     <= text_d;
            key_q      <= key_d;
            round_q    <= round_d;
            wd_cnt_q   <= wd_cnt_d;
            out_text_q <= out_text_d;
        end
    end

    // All handshake/status outputs are pure state decodes, so an asynchronous
    // reset takes effect on them immediately.
    assign in_ready    = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign out_valid   = (state_q == S_OUT);
    assign error       = (state_q == S_FAULT);
    assign core_enable = (state_q == S_ISSUE);
    assign out_text    = out_text_q;
    assign core_text   = text_q;
    assign core_key    = key_q;
    assign core_round  = round_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
module tb_aes_round_sequencer;

    localparam int NR     = 10;
    localparam int CORE_D = 5;

    localparam logic [127:0] C1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] C1_PT  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] C1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] B_KEY  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] B_PT   = 128'h340737e0a29831318d305a88a8f64332;
    localparam logic [127:0] B_CT   = 128'h320b6a19978511dcfb09dc021d842539;

    logic         clock;
    logic         resetn;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_text;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_text;
    logic         busy;
    logic         error;
    logic         err_clr;
    logic         core_enable;
    logic [127:0] core_text;
    logic [127:0] core_key;
    logic [3:0]   core_round;
    logic [127:0] core_o_text;
    logic [127:0] core_rkey;
    logic         core_done;
    logic         core_done_m;
    logic         spur_done;
    logic         hang;

    assign core_done = core_done_m | spur_done;

    aes_round_sequencer #(.NUM_ROUNDS(NR), .TIMEOUT(64)) dut (
        .clock(clock), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_text(in_text), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_text(out_text),
        .busy(busy), .error(error), .err_clr(err_clr),
        .core_enable(core_enable), .core_text(core_text), .core_key(core_key),
        .core_round(core_round), .core_o_text(core_o_text), .core_rkey(core_rkey),
        .core_done(core_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec;
    int n_fail;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- AES reference model ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) + affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] byt(input logic [127:0] v, input int i);
        return v[8*i +: 8];
    endfunction

    // One core round: key schedule step, SubBytes, ShiftRows, MixColumns
    // (skipped in the last round), AddRoundKey with the new key.
    function automatic void aes_round(input logic [127:0] s, input logic [127:0] k,
                                      input int r, output logic [127:0] o,
                                      output logic [127:0] nk_o);
        logic [7:0]   rc = 8'h01;
        logic [31:0]  tw;
        logic [127:0] nk;
        logic [127:0] ns;
        for (int i = 0; i < r; i++) rc = xt(rc);
        tw = {sbox[byt(k, 12)], sbox[byt(k, 15)], sbox[byt(k, 14)], sbox[byt(k, 13)] ^ rc};
        nk[31:0]   = k[31:0]   ^ tw;
        nk[63:32]  = k[63:32]  ^ nk[31:0];
        nk[95:64]  = k[95:64]  ^ nk[63:32];
        nk[127:96] = k[127:96] ^ nk[95:64];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                ns[8*(rr + 4*c) +: 8] = sbox[byt(s, rr + 4*((c + rr) % 4))];
        if (r != NR - 1) begin
            for (int c = 0; c < 4; c++) begin
                logic [7:0] a0, a1, a2, a3;
                a0 = byt(ns, 4*c); a1 = byt(ns, 4*c+1); a2 = byt(ns, 4*c+2); a3 = byt(ns, 4*c+3);
                ns[8*(4*c)   +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                ns[8*(4*c+1) +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                ns[8*(4*c+2) +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                ns[8*(4*c+3) +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        o    = ns ^ nk;
        nk_o = (r == NR - 1) ? {4{32'ha5a5c3c3}} : nk;
    endfunction

    function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s = pt ^ key;
        logic [127:0] k = key;
        logic [127:0] s2, k2;
        for (int r = 0; r < NR; r++) begin
            aes_round(s, k, r, s2, k2);
            s = s2;
            k = k2;
        end
        return s;
    endfunction

    // ---------------- round core stub (real AES round, done D cycles later) ----------------
    initial begin
        logic [127:0] t, k, o, nk;
        int r;
        bit abort;
        core_done_m = 1'b0;
        core_o_text = '0;
        core_rkey   = '0;
        forever begin
            @(negedge clock);
            if (resetn && core_enable && !hang) begin
                t = core_text; k = core_key; r = int'(core_round); abort = 0;
                for (int i = 0; i < CORE_D; i++) begin
                    @(posedge clock);
                    if (!resetn) abort = 1;
                end
                if (!abort) begin
                    #1 core_done_m = 1'b1;
                    @(posedge clock);
                    #1 core_done_m = 1'b0;
                    aes_round(t, k, r, o, nk);
                    core_o_text = o;
                    core_rkey   = nk;
                end
            end
        end
    end

    // ---------------- compare process ----------------
    logic [127:0] exp_q [$];
    int           en_cyc [$];
    int           en_rnd [$];

    initial begin
        logic         prev_ov, prev_or, prev_en;
        logic [127:0] prev_txt;
        prev_ov = 0; prev_or = 0; prev_en = 0; prev_txt = '0;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                exp_q.delete();
                prev_ov = 0; prev_or = 0; prev_en = 0;
            end else begin
                if (error) exp_q.delete();
                if (in_valid && in_ready) exp_q.push_back(aes128(in_text, in_key));
                check("busy_vs_ready", busy, !in_ready);
                check("round_range", core_round <= 4'(NR - 1), 1);
                check("enable_one_cycle", core_enable && prev_en, 0);
                check("enable_in_fault", core_enable && error, 0);
                if (core_enable) begin
                    en_cyc.push_back(cyc);
                    en_rnd.push_back(int'(core_round));
                end
                if (prev_ov && !prev_or) begin
                    check("hold_valid", out_valid, 1);
                    check("hold_text", out_text, prev_txt);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check("out_expected", exp_q.size(), 1);
                    else check("out_text_model", out_text, exp_q.pop_front());
                end
                prev_ov = out_valid; prev_or = out_ready; prev_en = core_enable; prev_txt = out_text;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input logic [127:0] pt, input logic [127:0] k, input bit keep,
                        output int t0);
        @(posedge clock);
        #1 in_valid = 1'b1; in_text = pt; in_key = k;
        t0 = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (in_ready) begin
                t0 = cyc;
                break;
            end
        end
        if (t0 < 0) check("accept_timeout", 0, 1);
        if (!keep) begin
            @(posedge clock);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_ov(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (out_valid) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check("out_valid_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int t0, tov, tacc, terr, t0b, tw;
        n_vec = 0; n_fail = 0;
        resetn = 1'b0; in_valid = 1'b0; in_text = '0; in_key = '0;
        out_ready = 1'b0; err_clr = 1'b0; spur_done = 1'b0; hang = 1'b0;

        build_sbox();
        check("sbox_00", sbox[8'h00], 8'h63);
        check("sbox_53", sbox[8'h53], 8'hed);
        check("model_c1", aes128(C1_PT, C1_KEY), C1_CT);
        check("model_b", aes128(B_PT, B_KEY), B_CT);

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_error", error, 0);
        check("rst_core_enable", core_enable, 0);
        check("rst_out_text", out_text, 0);
        check("rst_core_text", core_text, 0);
        check("rst_core_key", core_key, 0);
        check("rst_core_round", core_round, 0);
        @(posedge clock);
        #2 resetn = 1'b1;

        // Spurious core_done in IDLE
        @(posedge clock);
        #1 spur_done = 1'b1;
        @(posedge clock);
        #1 spur_done = 1'b0;
        @(negedge clock);
        check("spur_in_ready", in_ready, 1);
        check("spur_busy", busy, 0);

        // C.1 vector with round timing, in_valid held for a second block, backpressure
        en_cyc.delete(); en_rnd.delete();
        send(C1_PT, C1_KEY, 1, t0);
        @(posedge clock);
        #1 in_text = B_PT; in_key = B_KEY;
        wait_ov(200, tov);
        check("latency", tov, t0 + 71);
        check("enable_count", en_cyc.size(), NR);
        for (int k = 0; k < en_cyc.size() && k < NR; k++) begin
            check("enable_cycle", en_cyc[k], t0 + 1 + 7 * k);
            check("enable_round", en_rnd[k], k);
        end
        check("c1_out_text", out_text, C1_CT);
        check("c1_error", error, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_text", out_text, C1_CT);
            check("bp_in_ready", in_ready, 0);
        end
        @(posedge clock);
        #1 out_ready = 1'b1;
        @(negedge clock);
        tacc = cyc;
        @(negedge clock);
        check("idle_after_accept", in_ready, 1);
        check("valid_drop", out_valid, 0);
        @(posedge clock);
        #1 in_valid = 1'b0;
        t0b = tacc + 1;
        wait_ov(200, tov);
        check("second_latency", tov, t0b + 71);
        check("b_out_text", out_text, B_CT);
        @(negedge clock);
        check("b_back_idle", in_ready, 1);

        // Watchdog
        hang = 1'b1;
        en_cyc.delete(); en_rnd.delete();
        send(C1_PT, C1_KEY, 0, t0);
        terr = -1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clock);
            if (error) begin
                terr = cyc;
                break;
            end
        end
        check("wd_error_cycle", terr, t0 + 2 + 64);
        for (int i = 0; i < 10; i++) @(negedge clock);
        check("wd_enable_count", en_cyc.size(), 1);
        check("wd_error_sticky", error, 1);
        check("wd_in_ready", in_ready, 0);
        @(posedge clock);
        #1 err_clr = 1'b1;
        @(posedge clock);
        #1 err_clr = 1'b0;
        @(negedge clock);
        check("clr_error", error, 0);
        check("clr_in_ready", in_ready, 1);
        hang = 1'b0;
        send(B_PT, B_KEY, 0, t0);
        wait_ov(200, tov);
        check("post_fault_text", out_text, B_CT);
        check("post_fault_error", error, 0);

        // Reset during round 4
        tw = -1;
        send(C1_PT, C1_KEY, 0, t0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (core_enable && core_round == 4'd4) begin
                tw = cyc;
                break;
            end
        end
        check("reach_round4", tw >= 0, 1);
        @(posedge clock);
        #3 resetn = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_out_valid", out_valid, 0);
        repeat (3) @(posedge clock);
        #3 resetn = 1'b1;
        send(C1_PT, C1_KEY, 0, t0);
        wait_ov(200, tov);
        check("after_reset_text", out_text, C1_CT);
        check("after_reset_error", error, 0);
        @(negedge clock);
        out_ready = 1'b0;
        repeat (3) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
